muldiv_sequencer: RTL and testbench

- Multi-cycle controller for the HI/LO multiply/divide resource of the MIPS CPU datapath.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO ops from decode and runs an iterative shift-add multiply or a restoring divide.
- Owns the architectural HI/LO registers.
- Asserts busy so decode stalls MFHI/MFLO and any new mult/div op until the result commits.

---
 rtl/muldiv_pkg.sv | 44 ++++
 rtl/muldiv_sequencer_if.sv | 40 ++++
 rtl/muldiv_iter_dp.sv | 78 +++++++
 rtl/muldiv_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared types and helpers for the HI/LO multiply/divide sequencer.
//   muldiv_op_t    : op_code encodings presented by decode (6 and 7 reserved)
//   muldiv_state_t : sequencer FSM states
//   MULDIV_WIDTH   : operand width the helpers below are sized for
//   ITER           : iterations per multiply/divide (one bit per cycle)
//   abs_w, negate_w, negate_dw : two's complement sign-fix helpers
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int ITER         = MULDIV_WIDTH;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } muldiv_state_t;

    function automatic logic [MULDIV_WIDTH-1:0] negate_w(input logic [MULDIV_WIDTH-1:0] x);
        return (~x) + MULDIV_WIDTH'(1);
    endfunction

    function automatic logic [2*MULDIV_WIDTH-1:0] negate_dw(input logic [2*MULDIV_WIDTH-1:0] x);
        return (~x) + (2*MULDIV_WIDTH)'(1);
    endfunction

    // The most negative value maps onto itself, which is exactly the
    // unsigned magnitude the iterative datapath needs.
    function automatic logic [MULDIV_WIDTH-1:0] abs_w(input logic [MULDIV_WIDTH-1:0] x);
        return x[MULDIV_WIDTH-1] ? negate_w(x) : x;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Decode <-> multiply/divide unit handshake.
//   op_valid/op_ready : op accepted when both are high at a clock edge
//   op_code           : muldiv_op_t encoding
//   rs_content        : operand A (multiplicand, dividend, MTHI/MTLO data)
//   rt_content        : operand B (multiplier, divisor)
//   flush             : abort the in-flight op
//   busy, done        : stall indication and one-cycle completion pulse
//   hi, lo            : architectural HI/LO
// Modports: master = decode side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
);

    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] rs_content;
    logic [WIDTH-1:0] rt_content;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op_code, rs_content, rt_content, flush,
        input  op_ready, busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op_code, rs_content, rt_content, flush,
        output op_ready, busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_iter_dp.sv
// ---------------------------------------------------------------------------
// muldiv_iter_dp
// One-bit-per-cycle datapath shared by multiply and restoring divide.
// A single 2*WIDTH accumulator holds {upper, lower}:
//   multiply : {partial product, remaining multiplier}, shifts right
//   divide   : {remainder, dividend/quotient},          shifts left
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   load         : capture opnd_in (multiplicand or divisor) and lo_in
//                  (multiplier or dividend); upper half cleared
//   step         : perform one iteration
//   is_div       : selects the divide iteration when stepping
//   acc          : current accumulator contents
// ---------------------------------------------------------------------------
module muldiv_iter_dp
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   opnd_in,
    input  logic [WIDTH-1:0]   lo_in,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;

    // Multiply: the add carries into bit WIDTH, which becomes the new MSB
    // after the right shift.
    // Divide: a negative trial (MSB set) means restore, i.e. keep the
    // shifted remainder and shift in a 0 quotient bit.
    always_comb begin
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        addend  = acc_q[0] ? opnd_q : '0;
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, opnd_q};

        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, lo_in};
            opnd_d = opnd_in;
        end else if (step) begin
            if (is_div) begin
                if (trial[WIDTH+1]) begin
                    acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle controller for the MIPS HI/LO multiply/divide resource.
// Owns HI/LO, runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) one bit
// per cycle in muldiv_iter_dp, and writes MTHI/MTLO directly.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset (wins over flush)
//   bus     : muldiv_sequencer_if.slave (op handshake, flush, busy, done,
//             hi, lo)
// Timing: accept at edge 0, RUN on edges 1..WIDTH, FIN on edge WIDTH+1,
// done and new HI/LO visible in the following cycle.
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies leave RUN as soon
// as the unprocessed multiplier bits are all zero and the accumulator is
// realigned by a barrel shift in FIN. Divides are unaffected.
// WIDTH must equal muldiv_pkg::MULDIV_WIDTH; the sign-fix helpers are
// sized from the package.
// ---------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    muldiv_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               dp_load;
    logic               dp_step;
    logic [WIDTH-1:0]   dp_opnd;
    logic [WIDTH-1:0]   dp_lo;
    logic [2*WIDTH-1:0] acc;

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               signs_differ;

    logic [2*WIDTH-1:0] result;
    logic               rest_zero;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    muldiv_iter_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (dp_load),
        .step    (dp_step),
        .is_div  (is_div_q),
        .opnd_in (dp_opnd),
        .lo_in   (dp_lo),
        .acc     (acc)
    );

    // Magnitudes are taken at acceptance; the sign fix is applied in FIN.
    assign op_signed    = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
    assign a_mag        = op_signed ? abs_w(bus.rs_content) : bus.rs_content;
    assign b_mag        = op_signed ? abs_w(bus.rt_content) : bus.rt_content;
    assign signs_differ = op_signed && (bus.rs_content[WIDTH-1] ^ bus.rt_content[WIDTH-1]);

`ifdef MULDIV_EARLY_TERM_EN
    // Before the step at counter value c, the still-unprocessed multiplier
    // bits sit in acc[c:0]. If acc[c:1] is zero, this step consumes the last
    // set bit and the remaining c steps would be pure right shifts.
    always_comb begin
        rest_zero = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            if ((i <= int'(cnt_q)) && acc[i]) begin
                rest_zero = 1'b0;
            end
        end
    end

    // The counter is frozen on an early exit, so it equals the number of
    // skipped shifts. A normal exit leaves it at zero.
    assign result = acc >> cnt_q;
`else
    assign rest_zero = 1'b0;
    assign result    = acc;
`endif

    // Divide by zero forces LO to all ones. HI falls out naturally: the
    // remainder is |dividend| and the dividend-sign fix restores rs_content.
    assign product   = neg_q ? negate_dw(result) : result;
    assign quotient  = div_zero_q ? '1
                     : (neg_q ? negate_w(result[WIDTH-1:0]) : result[WIDTH-1:0]);
    assign remainder = rem_neg_q ? negate_w(result[2*WIDTH-1:WIDTH])
                                 : result[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        dp_opnd    = '0;
        dp_lo      = '0;

        case (state_q)
            ST_IDLE: begin
                // Flush outranks acceptance; reserved codes are swallowed.
                if (!bus.flush && bus.op_valid) begin
                    case (bus.op_code)
                        OP_MTHI: begin
                            hi_d   = bus.rs_content;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.rs_content;
                            done_d = 1'b1;
                        end
                        OP_MULT, OP_MULTU: begin
                            dp_load    = 1'b1;
                            dp_opnd    = a_mag;
                            dp_lo      = b_mag;
                            is_div_d   = 1'b0;
                            neg_d      = signs_differ;
                            rem_neg_d  = 1'b0;
                            div_zero_d = 1'b0;
                            cnt_d      = CNT_W'(ITER - 1);
                            state_d    = ST_RUN;
`ifdef MULDIV_EARLY_TERM_EN
                            if (bus.rt_content == '0) begin
                                state_d = ST_FIN;
                            end
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            dp_load    = 1'b1;
                            dp_opnd    = b_mag;
                            dp_lo      = a_mag;
                            is_div_d   = 1'b1;
                            neg_d      = signs_differ;
                            rem_neg_d  = op_signed && bus.rs_content[WIDTH-1];
                            div_zero_d = (bus.rt_content == '0);
                            cnt_d      = CNT_W'(ITER - 1);
                            state_d    = ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end

            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    dp_step = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_FIN;
                    end else if (!is_div_q && rest_zero) begin
                        state_d = ST_FIN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = remainder;
                        lo_d = quotient;
                    end else begin
                        hi_d = product[2*WIDTH-1:WIDTH];
                        lo_d = product[WIDTH-1:0];
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign bus.op_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer: directed vector table, random
// ops against an arithmetic reference model, and hand-written sequences for
// back-to-back ops, flush, reserved codes and reset mid-operation.
// Latency n counts clock edges after the accept edge; outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset_n;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        string       name;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Edges from accept to the done cycle, derived from the operand bits.
    function automatic int expLatency(input logic [2:0] op, input logic [31:0] b);
        logic [31:0] m;
        int hb;
        if (op > 3'd3) return 0;
        m  = b;
        hb = -1;
`ifdef MULDIV_EARLY_TERM_EN
        if (op <= 3'd1) begin
            if (op == 3'd0 && b[31]) m = 32'd0 - b;
            for (int i = 0; i < 32; i++) if (m[i]) hb = i;
            if (hb < 0) return 1;
            return hb + 2;
        end
`endif
        return 33;
    endfunction

    task automatic modelResult(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b,
                               output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFFFFFF; end
                else begin
                    q = sa / sb; r = sa % sb;
                    qv = 64'(q); rv = 64'(r);
                    hi = rv[31:0]; lo = qv[31:0];
                end
            end
            3'd3: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFFFFFF; end
                else begin hi = a % b; lo = a / b; end
            end
            default: ;
        endcase
    endtask

    // Drives the op from a falling edge, waits (bounded) for op_ready, lets
    // the accept edge pass and returns on the next falling edge (n = 0).
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output bit accepted);
        int guard = 0;
        bus.op_valid   = 1'b1;
        bus.op_code    = op;
        bus.rs_content = a;
        bus.rt_content = b;
        while (!bus.op_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        accepted = bus.op_ready;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int n, output bit busyOk);
        n      = 0;
        busyOk = 1'b1;
        while (!bus.done && n < limit) begin
            if (!bus.busy) busyOk = 1'b0;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input string name);
        bit acc, busyOk;
        int n;
        applyStimulus(op, a, b, acc);
        checkOutput({name, " accepted"}, 32'(acc), 32'd1);
        waitDone(60, n, busyOk);
        checkOutput({name, " latency"}, 32'(n), 32'(expLatency(op, b)));
        checkOutput({name, " hi"}, bus.hi, expHi);
        checkOutput({name, " lo"}, bus.lo, expLo);
        if (op <= 3'd3) begin
            checkOutput({name, " busy"}, 32'(busyOk), 32'd1);
            checkOutput({name, " ready at done"}, 32'(bus.op_ready), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit acc, busyOk, sawDone;
        int n, flushAt;
        logic [2:0]  rop;
        logic [31:0] ra, rb, mHi, mLo;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max"};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3x7"};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
        vecs[3]  = '{3'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu 100/0"};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div overflow"};
        vecs[5]  = '{3'd1, 32'h00001234, 32'h00000001, 32'h00000000, 32'h00001234, "multu x1"};
        vecs[6]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult minxmin"};
        vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};
        vecs[8]  = '{3'd1, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'h00000000, "multu x0"};
        vecs[9]  = '{3'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, "div -8/0"};
        vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu max/16"};
        vecs[11] = '{3'd0, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, "mult 5x-1"};

        reset_n        = 1'b0;
        bus.op_valid   = 1'b0;
        bus.op_code    = 3'd0;
        bus.rs_content = 32'd0;
        bus.rt_content = 32'd0;
        bus.flush      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset hi", bus.hi, 32'd0);
        checkOutput("reset lo", bus.lo, 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset ready", 32'(bus.op_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, vecs[i].name);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(0, 15));
                3: rb = 32'd0 - 32'($urandom_range(1, 9));
                default: ;
            endcase
            modelResult(rop, ra, rb, mHi, mLo);
            runOp(rop, ra, rb, mHi, mLo, $sformatf("rand%0d op%0d", i, rop));
        end

        // MTHI immediately followed by MULTU, with a third op held while busy.
        bus.op_valid   = 1'b1;
        bus.op_code    = 3'd4;
        bus.rs_content = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mthi done", 32'(bus.done), 32'd1);
        checkOutput("mthi hi", bus.hi, 32'h12345678);
        bus.op_code    = 3'd1;
        bus.rs_content = 32'd2;
        bus.rt_content = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.rs_content = 32'd7;
        bus.rt_content = 32'd7;
        checkOutput("b2b busy", 32'(bus.busy), 32'd1);
        waitDone(60, n, busyOk);
        checkOutput("b2b latency", 32'(n), 32'(expLatency(3'd1, 32'd3)));
        checkOutput("b2b hi", bus.hi, 32'd0);
        checkOutput("b2b lo", bus.lo, 32'd6);
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        waitDone(60, n, busyOk);
        checkOutput("held latency", 32'(n), 32'(expLatency(3'd1, 32'd7)));
        checkOutput("held lo", bus.lo, 32'd49);

        // Flush mid-multiply leaves HI/LO alone and produces no done.
        applyStimulus(3'd4, 32'hAAAAAAAA, 32'd0, acc);
        applyStimulus(3'd5, 32'h55555555, 32'd0, acc);
        applyStimulus(3'd1, 32'd5, 32'd5, acc);
        flushAt = expLatency(3'd1, 32'd5) - 2;
        if (flushAt > 9) flushAt = 9;
        sawDone = 1'b0;
        n = 0;
        while (n < flushAt) begin
            if (bus.done) sawDone = 1'b1;
            @(negedge clk);
            n++;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        checkOutput("flush ready", 32'(bus.op_ready), 32'd1);
        checkOutput("flush busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (bus.done) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("flush no done", 32'(sawDone), 32'd0);
        checkOutput("flush hi", bus.hi, 32'hAAAAAAAA);
        checkOutput("flush lo", bus.lo, 32'h55555555);

        // Flush in IDLE blocks acceptance.
        bus.flush      = 1'b1;
        bus.op_valid   = 1'b1;
        bus.op_code    = 3'd4;
        bus.rs_content = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        checkOutput("idle flush done", 32'(bus.done), 32'd0);
        checkOutput("idle flush hi", bus.hi, 32'hAAAAAAAA);

        // Reserved op code: accepted, no write, no done.
        applyStimulus(3'd6, 32'h11111111, 32'd2, acc);
        checkOutput("reserved done", 32'(bus.done), 32'd0);
        checkOutput("reserved busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("reserved hi", bus.hi, 32'hAAAAAAAA);
        checkOutput("reserved lo", bus.lo, 32'h55555555);

        // Reset in the middle of a divide.
        applyStimulus(3'd3, 32'd1000, 32'd7, acc);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("midreset hi", bus.hi, 32'd0);
        checkOutput("midreset lo", bus.lo, 32'd0);
        checkOutput("midreset busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset ready", 32'(bus.op_ready), 32'd1);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("midreset no done", 32'(sawDone), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
